m_uart_loader: RTL and testbench

Boot-time program loader that sits directly upstream of the instruction/data memories of the pipelined processor. It receives a program image over a UART serial line, assembles little-endian 32-bit words, and drives a write port into an `m_memory`-style 2048-word RAM. It holds the processor in reset (`r_busy`) until the image is complete, so the core starts fetching at PC 0 with the new program already in place.

---
 rtl/m_uart_loader_pkg.sv | 29 ++
 rtl/m_uart_rx.sv | 95 +++++++++
 rtl/m_uart_loader.sv | 110 +++++++++++
 tb/tb_m_uart_loader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/m_uart_loader_pkg.sv
// Shared encodings and helpers for the UART boot loader and its receiver.
package m_uart_loader_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    LD_HDR0,
    LD_HDR1,
    LD_B0,
    LD_B1,
    LD_B2,
    LD_B3,
    LD_DONE,
    LD_ERR
  } ld_state_t;

  localparam int DATA_W = 32;

  // A header count is legal when it names at least one word and fits the memory.
  function automatic logic count_ok(input logic [31:0] cnt, input logic [31:0] limit);
    return (cnt != 32'd0) && (cnt <= limit);
  endfunction

endpackage

// File: rtl/m_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, false-start rejection.
module m_uart_rx
  import m_uart_loader_pkg::*;
#(
  parameter int BAUD_DIV = 868
) (
  input  logic       w_clk,
  input  logic       w_rst,
  input  logic       w_rxd,
  output logic [7:0] w_byte,
  output logic       w_bvalid,
  output logic       w_ferr
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);

  rx_state_t state, nxt;
  logic [2:0]    sync;  // [1:0] synchronizer, [2] previous value for edge detect
  logic [CW-1:0] cnt;
  logic [2:0]    bitn;
  logic [7:0]    shreg;
  logic          rx, fall, tick_half, tick_full;

  assign rx        = sync[1];
  assign fall      = sync[2] & ~sync[1];
  assign tick_half = (cnt == HALF_M1);
  assign tick_full = (cnt == FULL_M1);

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      sync  <= 3'b111;
      state <= RX_IDLE;
    end else begin
      sync  <= {sync[1:0], w_rxd};
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      RX_IDLE:  if (fall) nxt = RX_START;
      RX_START: if (tick_half) nxt = rx ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick_full && bitn == 3'd7) nxt = RX_STOP;
      RX_STOP:  if (tick_full) nxt = RX_IDLE;
      default:  nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      cnt      <= '0;
      bitn     <= '0;
      shreg    <= '0;
      w_byte   <= '0;
      w_bvalid <= 1'b0;
      w_ferr   <= 1'b0;
    end else begin
      w_bvalid <= 1'b0;
      w_ferr   <= 1'b0;
      case (state)
        RX_START: cnt <= tick_half ? '0 : cnt + 1'b1;
        RX_DATA: begin
          if (tick_full) begin
            cnt   <= '0;
            shreg <= {rx, shreg[7:1]};
            bitn  <= bitn + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (tick_full) begin
            cnt <= '0;
            if (rx) begin
              w_byte   <= shreg;
              w_bvalid <= 1'b1;
            end else begin
              w_ferr <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt  <= '0;
          bitn <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/m_uart_loader.sv
// Boot loader: UART image (16-bit LE word count, then LE 32-bit words) into a RAM write port.
module m_uart_loader
  import m_uart_loader_pkg::*;
#(
  parameter int BAUD_DIV = 868,
  parameter int WORDS    = 2048,
  parameter int ADDR_W   = 11
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_rxd,
  output logic              r_we,
  output logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_data,
  output logic              r_busy,
  output logic              r_done,
  output logic              r_err
);

  localparam int CNT_W = ADDR_W + 1;

  logic [7:0] rx_byte;
  logic       rx_bvalid, rx_ferr;

  m_uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .w_clk    (w_clk),
    .w_rst    (w_rst),
    .w_rxd    (w_rxd),
    .w_byte   (rx_byte),
    .w_bvalid (rx_bvalid),
    .w_ferr   (rx_ferr)
  );

  ld_state_t        state, nxt;
  logic [7:0]       cnt_lo;
  logic [CNT_W-1:0] count, widx;
  logic [23:0]      word;
  logic             loading, last_word, hdr_ok;
  logic             we_nxt, done_nxt, err_nxt;

  assign loading   = (state != LD_DONE) && (state != LD_ERR);
  assign last_word = ((widx + 1'b1) == count);
  // Validate the full 16-bit header before it is narrowed into the count register.
  assign hdr_ok    = count_ok({16'd0, rx_byte, cnt_lo}, 32'(WORDS));

  always_ff @(posedge w_clk) begin
    if (w_rst) state <= LD_HDR0;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (loading && rx_ferr) begin
      nxt = LD_ERR;
    end else if (rx_bvalid) begin
      case (state)
        LD_HDR0: nxt = LD_HDR1;
        LD_HDR1: nxt = hdr_ok ? LD_B0 : LD_ERR;
        LD_B0:   nxt = LD_B1;
        LD_B1:   nxt = LD_B2;
        LD_B2:   nxt = LD_B3;
        LD_B3:   nxt = last_word ? LD_DONE : LD_B0;
        default: nxt = state;
      endcase
    end
  end

  // done follows the state a cycle late so the final write lands before the core leaves reset.
  always_comb begin
    we_nxt   = rx_bvalid && (state == LD_B3);
    done_nxt = (state == LD_DONE);
    err_nxt  = (nxt == LD_ERR);
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      cnt_lo <= '0;
      count  <= '0;
      widx   <= '0;
      word   <= '0;
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_busy <= 1'b1;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_we   <= we_nxt;
      r_busy <= ~done_nxt;
      r_done <= done_nxt;
      r_err  <= err_nxt;
      if (rx_bvalid) begin
        case (state)
          LD_HDR0: cnt_lo <= rx_byte;
          LD_HDR1: count <= CNT_W'({rx_byte, cnt_lo});
          LD_B0:   word[7:0] <= rx_byte;
          LD_B1:   word[15:8] <= rx_byte;
          LD_B2:   word[23:16] <= rx_byte;
          LD_B3: begin
            r_data <= {rx_byte, word};
            r_addr <= widx[ADDR_W-1:0];
            widx   <= widx + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_m_uart_loader.sv
// Directed bench: serial image stimulus, write-queue model checked every cycle, memory readback.
module tb_m_uart_loader;

  localparam int BAUD   = 16;
  localparam int WORDS  = 2048;
  localparam int ADDR_W = 11;

  logic              w_clk = 1'b0;
  logic              w_rst = 1'b1;
  logic              w_rxd = 1'b1;
  logic              r_we, r_busy, r_done, r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_data;

  m_uart_loader #(.BAUD_DIV(BAUD), .WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
    .w_clk  (w_clk),
    .w_rst  (w_rst),
    .w_rxd  (w_rxd),
    .r_we   (r_we),
    .r_addr (r_addr),
    .r_data (r_data),
    .r_busy (r_busy),
    .r_done (r_done),
    .r_err  (r_err)
  );

  always #5 w_clk = ~w_clk;

  int checks = 0;
  int failures = 0;
  int we_cnt = 0;

  logic [31:0]       mem [0:WORDS-1];
  logic [31:0]       img [$];
  logic [ADDR_W-1:0] qa  [$];
  logic [31:0]       qd  [$];
  bit chk_en = 0, expect_ok = 0, model_done = 0, done_pending = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // RAM model capturing the write port
  always @(posedge w_clk) begin
    if (r_we) begin
      mem[r_addr] <= r_data;
      we_cnt <= we_cnt + 1;
    end
  end

  // Per-cycle compare against the expected write list and completion rule
  always @(negedge w_clk) begin
    if (chk_en && !w_rst) begin
      if (done_pending) begin
        model_done = 1;
        done_pending = 0;
      end
      chk("done", r_done, model_done);
      chk("busy", r_busy, !model_done);
      if (expect_ok) chk("err", r_err, 0);
      if (r_we) begin
        if (qa.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_we addr=%0h data=%0h required=no write", r_addr, r_data);
        end else begin
          chk("we_addr", r_addr, qa.pop_front());
          chk("we_data", r_data, qd.pop_front());
          if (qa.size() == 0 && expect_ok) done_pending = 1;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge w_clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    w_rxd = 1'b0;
    idle(BAUD);
    for (int i = 0; i < 8; i++) begin
      w_rxd = b[i];
      idle(BAUD);
    end
    w_rxd = stop_ok;
    idle(BAUD);
    w_rxd = 1'b1;
  endtask

  task automatic do_reset();
    chk_en = 0;
    @(negedge w_clk);
    w_rst = 1'b1;
    w_rxd = 1'b1;
    idle(3);
    chk("rst_we", r_we, 0);
    chk("rst_addr", r_addr, 0);
    chk("rst_data", r_data, 0);
    chk("rst_busy", r_busy, 1);
    chk("rst_done", r_done, 0);
    chk("rst_err", r_err, 0);
    qa.delete();
    qd.delete();
    model_done = 0;
    done_pending = 0;
    w_rst = 1'b0;
    idle(4);
  endtask

  // Send header n then every word of img; queue the writes the loader must make.
  task automatic send_image(input logic [15:0] n, input bit ok);
    expect_ok = ok;
    if (ok) begin
      for (int k = 0; k < img.size(); k++) begin
        qa.push_back(ADDR_W'(k));
        qd.push_back(img[k]);
      end
    end
    chk_en = 1;
    send_byte(n[7:0], 1'b1);
    send_byte(n[15:8], 1'b1);
    for (int k = 0; k < img.size(); k++) begin
      logic [31:0] w;
      w = img[k];
      for (int j = 0; j < 4; j++) send_byte(w[8*j +: 8], 1'b1);
    end
  endtask

  task automatic wait_done();
    for (int c = 0; c < 400 && !r_done; c++) @(negedge w_clk);
    chk("done_timeout", r_done, 1);
    chk("writes_left", qa.size(), 0);
  endtask

  int we0;

  initial begin
    do_reset();

    // single word
    img = '{32'hDEADBEEF};
    we0 = we_cnt;
    send_image(16'd1, 1'b1);
    wait_done();
    chk("t1_we_count", we_cnt - we0, 1);
    chk("t1_addr", r_addr, 0);
    chk("t1_data", r_data, 32'hDEADBEEF);
    chk("t1_busy", r_busy, 0);
    chk("t1_mem0", mem[0], 32'hDEADBEEF);

    // three back-to-back words
    do_reset();
    img = '{32'h00000020, 32'h11223344, 32'hFFFFFFFF};
    we0 = we_cnt;
    send_image(16'd3, 1'b1);
    wait_done();
    chk("t2_we_count", we_cnt - we0, 3);
    chk("t2_mem0", mem[0], 32'h00000020);
    chk("t2_mem1", mem[1], 32'h11223344);
    chk("t2_mem2", mem[2], 32'hFFFFFFFF);
    chk("t2_addr", r_addr, 2);

    // framing error on second data byte
    do_reset();
    img.delete();
    we0 = we_cnt;
    send_image(16'd1, 1'b0);
    send_byte(8'hEF, 1'b1);
    send_byte(8'hBE, 1'b0);
    idle(20);
    chk("t3_err", r_err, 1);
    send_byte(8'hEF, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(8'hDE, 1'b1);
    idle(20);
    chk("t3_err_sticky", r_err, 1);
    chk("t3_busy", r_busy, 1);
    chk("t3_no_we", we_cnt - we0, 0);

    // short glitch then a valid load
    do_reset();
    chk_en = 1;
    expect_ok = 1;
    w_rxd = 1'b0;
    idle(4);
    w_rxd = 1'b1;
    idle(40);
    img = '{32'h12345678};
    we0 = we_cnt;
    send_image(16'd1, 1'b1);
    wait_done();
    chk("t4_we_count", we_cnt - we0, 1);
    chk("t4_data", r_data, 32'h12345678);

    // count of zero
    do_reset();
    img = '{32'hA5A5A5A5};
    we0 = we_cnt;
    send_image(16'd0, 1'b0);
    idle(20);
    chk("t5_err0", r_err, 1);
    chk("t5_busy0", r_busy, 1);
    chk("t5_no_we0", we_cnt - we0, 0);

    // count of 2049
    do_reset();
    we0 = we_cnt;
    send_image(16'h0801, 1'b0);
    idle(20);
    chk("t5_err2049", r_err, 1);
    chk("t5_no_we2049", we_cnt - we0, 0);

    // reset mid-image, then a fresh load from address 0
    do_reset();
    img = '{32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4};
    for (int k = 0; k < 3; k++) begin
      qa.push_back(ADDR_W'(k));
      qd.push_back(img[k]);
    end
    expect_ok = 1;
    chk_en = 1;
    send_byte(8'h03, 1'b1);
    send_byte(8'h00, 1'b1);
    for (int j = 0; j < 4; j++) send_byte(img[0][8*j +: 8], 1'b1);
    send_byte(8'hB4, 1'b1);
    send_byte(8'hB3, 1'b1);
    idle(4);
    chk("t6_partial_writes_left", qa.size(), 2);
    do_reset();
    img = '{32'h0BADF00D, 32'h00000001};
    we0 = we_cnt;
    send_image(16'd2, 1'b1);
    wait_done();
    chk("t6_we_count", we_cnt - we0, 2);
    chk("t6_mem0", mem[0], 32'h0BADF00D);
    chk("t6_mem1", mem[1], 32'h00000001);

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
